// File: rtl/mmio_bus_bridge.sv
// mmio_bus_bridge: decodes the page field of a host access against a
// per-slave page map, runs a request/ready handshake with the selected
// slave under a bounded wait, and returns registered read data or an
// error response for unmapped or timed-out accesses.
module mmio_bus_bridge #(
    parameter int                               NUM_SLAVES  = 4,
    parameter int                               DATA_WIDTH  = 32,
    parameter int                               ADDR_WIDTH  = 32,
    parameter int                               PAGE_LSB    = 8,
    parameter int                               PAGE_WIDTH  = 4,
    parameter logic [NUM_SLAVES*PAGE_WIDTH-1:0] SLAVE_PAGES = {4'd9, 4'd8, 4'd1, 4'd0},
    parameter int                               TIMEOUT     = 15,
    parameter logic [DATA_WIDTH-1:0]            ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             host_req,
    input  logic                             host_we,
    input  logic [ADDR_WIDTH-1:0]            host_addr,
    input  logic [DATA_WIDTH-1:0]            host_wd,
    output logic                             host_busy,
    output logic                             host_ready,
    output logic                             host_err,
    output logic [DATA_WIDTH-1:0]            host_rd,
    output logic [NUM_SLAVES-1:0]            s_sel,
    output logic [NUM_SLAVES-1:0]            s_we,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wd,
    input  logic [NUM_SLAVES-1:0]            s_ready,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rd,
    output logic [7:0]                       err_count,
    output logic [ADDR_WIDTH-1:0]            err_addr
);

    localparam int         IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [7:0]              r_cnt;
    logic [NUM_SLAVES-1:0]   r_sel;
    logic [NUM_SLAVES-1:0]   r_s_we;
    logic [ADDR_WIDTH-1:0]   r_s_addr;
    logic [DATA_WIDTH-1:0]   r_s_wd;
    logic                    r_busy;
    logic                    r_ready;
    logic                    r_err;
    logic [DATA_WIDTH-1:0]   r_rd;
    logic [7:0]              r_err_count;
    logic [ADDR_WIDTH-1:0]   r_err_addr;

    logic [PAGE_WIDTH-1:0]   w_page;
    logic                    w_hit;
    logic [IDX_W-1:0]        w_idx;
    logic [NUM_SLAVES-1:0]   w_onehot;
    logic                    w_rdy_sel;
    logic [DATA_WIDTH-1:0]   w_rd_sel;

    // Page decode: lowest-numbered slave whose map entry matches wins.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        w_page = host_addr[PAGE_LSB +: PAGE_WIDTH];
        w_hit  = 1'b0;
        w_idx  = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (SLAVE_PAGES[i*PAGE_WIDTH +: PAGE_WIDTH] == w_page) begin
                w_hit = 1'b1;
                w_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_onehot[i] = (w_idx == IDX_W'(i));
        end
    end

    // Pick the ready bit and read data of the latched slave; others are ignored.
    always_comb begin
        w_rdy_sel = 1'b0;
        w_rd_sel  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_rdy_sel = s_ready[i];
                w_rd_sel  = s_rd[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: asynchronous reset clears every output, so a mid-transaction reset drops s_sel at once.
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_sel       <= '0;
            r_s_we      <= '0;
            r_s_addr    <= '0;
            r_s_wd      <= '0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_rd        <= '0;
            r_err_count <= '0;
            r_err_addr  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (host_req) begin
                        r_s_addr <= host_addr;
                        r_s_wd   <= host_wd;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        if (w_hit) begin
                            r_idx   <= w_idx;
                            r_sel   <= w_onehot;
                            r_s_we  <= host_we ? w_onehot : '0;
                            r_state <= ST_WAIT;
                        end else begin
                            r_ready    <= 1'b1;
                            r_err      <= 1'b1;
                            r_rd       <= ERR_DATA;
                            r_err_addr <= host_addr;
                            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                            r_state    <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_rdy_sel) begin
                        r_rd    <= w_rd_sel;
                        r_err   <= 1'b0;
                        r_ready <= 1'b1;
                        r_sel   <= '0;
                        r_s_we  <= '0;
                        r_state <= ST_RESP;
                    end else if (r_cnt == LP_TO_LAST) begin
                        r_rd       <= ERR_DATA;
                        r_err      <= 1'b1;
                        r_ready    <= 1'b1;
                        r_err_addr <= r_s_addr;
                        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                        r_sel      <= '0;
                        r_s_we     <= '0;
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_sel   <= '0;
                    r_s_we  <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign host_busy  = r_busy;
    assign host_ready = r_ready;
    assign host_err   = r_err;
    assign host_rd    = r_rd;
    assign s_sel      = r_sel;
    assign s_we       = r_s_we;
    assign s_addr     = r_s_addr;
    assign s_wd       = r_s_wd;
    assign err_count  = r_err_count;
    assign err_addr   = r_err_addr;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Directed testbench for mmio_bus_bridge: default page map instance plus a
// second instance whose map has page 8 at both slave 1 and slave 2.
module tb_mmio_bus_bridge;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         host_req = 1'b0;
    logic         host_req2 = 1'b0;
    logic         host_we = 1'b0;
    logic [31:0]  host_addr = '0;
    logic [31:0]  host_wd = '0;
    logic [3:0]   s_ready = '0;
    logic [127:0] s_rd = {32'h1234_5678, 32'hCAFE_0002, 32'hBEEF_0001, 32'hA5A5_0000};

    logic         host_busy, host_ready, host_err;
    logic [31:0]  host_rd, s_addr, s_wd, err_addr;
    logic [3:0]   s_sel, s_we;
    logic [7:0]   err_count;

    logic         host_busy2, host_ready2, host_err2;
    logic [31:0]  host_rd2, s_addr2, s_wd2, err_addr2;
    logic [3:0]   s_sel2, s_we2;
    logic [7:0]   err_count2;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clock = ~clock;

    mmio_bus_bridge dut (
        .clock(clock), .reset(reset), .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wd(host_wd), .host_busy(host_busy),
        .host_ready(host_ready), .host_err(host_err), .host_rd(host_rd),
        .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wd(s_wd),
        .s_ready(s_ready), .s_rd(s_rd), .err_count(err_count), .err_addr(err_addr)
    );

    mmio_bus_bridge #(.SLAVE_PAGES({4'd9, 4'd8, 4'd8, 4'd0})) dut_dup (
        .clock(clock), .reset(reset), .host_req(host_req2), .host_we(host_we),
        .host_addr(host_addr), .host_wd(host_wd), .host_busy(host_busy2),
        .host_ready(host_ready2), .host_err(host_err2), .host_rd(host_rd2),
        .s_sel(s_sel2), .s_we(s_we2), .s_addr(s_addr2), .s_wd(s_wd2),
        .s_ready(s_ready), .s_rd(s_rd), .err_count(err_count2), .err_addr(err_addr2)
    );

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        vec_cnt++; if ({host_rd, err_addr, s_addr, s_wd} !== 128'd0) begin err_cnt++; $display("FAIL reset_data: got %h exp 0", {host_rd, err_addr, s_addr, s_wd}); end
        vec_cnt++; if ({err_count, s_sel, s_we} !== 16'd0) begin err_cnt++; $display("FAIL reset_sel_cnt: got %h exp 0", {err_count, s_sel, s_we}); end
        vec_cnt++; if ({host_ready, host_err, host_busy} !== 3'b000) begin err_cnt++; $display("FAIL reset_flags: got %b exp 000", {host_ready, host_err, host_busy}); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_read_hit();
        host_addr = 32'h0000_0904; host_we = 1'b0; host_req = 1'b1;
        tick(); // cycle 1
        host_req = 1'b0;
        vec_cnt++; if (s_sel !== 4'b1000) begin err_cnt++; $display("FAIL read_sel: got %b exp 1000", s_sel); end
        vec_cnt++; if (s_we !== 4'b0000) begin err_cnt++; $display("FAIL read_we: got %b exp 0000", s_we); end
        vec_cnt++; if (s_addr !== 32'h0000_0904) begin err_cnt++; $display("FAIL read_saddr: got %h exp 00000904", s_addr); end
        vec_cnt++; if ({host_busy, host_ready} !== 2'b10) begin err_cnt++; $display("FAIL read_busy_c1: got %b exp 10", {host_busy, host_ready}); end
        s_ready = 4'b1000;
        tick(); // cycle 2
        s_ready = 4'b0000;
        vec_cnt++; if ({host_ready, host_err} !== 2'b10) begin err_cnt++; $display("FAIL read_resp: got %b exp 10", {host_ready, host_err}); end
        vec_cnt++; if (host_rd !== 32'h1234_5678) begin err_cnt++; $display("FAIL read_rd: got %h exp 12345678", host_rd); end
        vec_cnt++; if (s_sel !== 4'b0000) begin err_cnt++; $display("FAIL read_sel_resp: got %b exp 0000", s_sel); end
        tick(); // cycle 3
        vec_cnt++; if ({host_ready, host_busy} !== 2'b00) begin err_cnt++; $display("FAIL read_idle: got %b exp 00", {host_ready, host_busy}); end
        vec_cnt++; if (host_rd !== 32'h1234_5678) begin err_cnt++; $display("FAIL read_rd_hold: got %h exp 12345678", host_rd); end
    endtask

    task automatic test_write_wait();
        host_addr = 32'h0000_0800; host_we = 1'b1; host_wd = 32'h5; host_req = 1'b1;
        tick();
        host_req = 1'b0; host_we = 1'b0; host_wd = 32'h0;
        for (int c = 1; c <= 3; c++) begin
            vec_cnt++; if ({s_sel, s_we} !== 8'b0100_0100) begin err_cnt++; $display("FAIL write_sel_we c%0d: got %b exp 01000100", c, {s_sel, s_we}); end
            vec_cnt++; if (s_wd !== 32'h5) begin err_cnt++; $display("FAIL write_wd c%0d: got %h exp 5", c, s_wd); end
            vec_cnt++; if (host_ready !== 1'b0) begin err_cnt++; $display("FAIL write_early_ready c%0d: got %b exp 0", c, host_ready); end
            if (c == 3) s_ready = 4'b0100;
            tick();
        end
        s_ready = 4'b0000;
        vec_cnt++; if ({host_ready, host_err} !== 2'b10) begin err_cnt++; $display("FAIL write_resp: got %b exp 10", {host_ready, host_err}); end
        vec_cnt++; if (host_rd !== 32'hCAFE_0002) begin err_cnt++; $display("FAIL write_rd: got %h exp cafe0002", host_rd); end
        tick();
    endtask

    task automatic test_miss();
        host_addr = 32'h0000_0500; host_req = 1'b1;
        tick(); // cycle 1
        host_req = 1'b0;
        vec_cnt++; if ({host_ready, host_err, host_busy} !== 3'b111) begin err_cnt++; $display("FAIL miss_flags: got %b exp 111", {host_ready, host_err, host_busy}); end
        vec_cnt++; if (host_rd !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL miss_rd: got %h exp deadbeef", host_rd); end
        vec_cnt++; if (s_sel !== 4'b0000) begin err_cnt++; $display("FAIL miss_sel: got %b exp 0000", s_sel); end
        vec_cnt++; if (err_addr !== 32'h0000_0500) begin err_cnt++; $display("FAIL miss_err_addr: got %h exp 00000500", err_addr); end
        vec_cnt++; if (err_count !== 8'd1) begin err_cnt++; $display("FAIL miss_err_count: got %0d exp 1", err_count); end
        tick(); // cycle 2
        vec_cnt++; if ({host_ready, host_busy, s_sel} !== 6'd0) begin err_cnt++; $display("FAIL miss_idle: got %b exp 0", {host_ready, host_busy, s_sel}); end
    endtask

    task automatic test_timeout();
        host_addr = 32'h0000_0000; host_req = 1'b1;
        tick();
        host_req = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            vec_cnt++; if ({s_sel, host_ready} !== 5'b0001_0) begin err_cnt++; $display("FAIL timeout_sel c%0d: got %b exp 00010", c, {s_sel, host_ready}); end
            tick();
        end
        vec_cnt++; if ({host_ready, host_err, s_sel} !== 6'b11_0000) begin err_cnt++; $display("FAIL timeout_resp: got %b exp 110000", {host_ready, host_err, s_sel}); end
        vec_cnt++; if (host_rd !== 32'hDEAD_BEEF) begin err_cnt++; $display("FAIL timeout_rd: got %h exp deadbeef", host_rd); end
        vec_cnt++; if ({err_count, err_addr} !== {8'd2, 32'h0}) begin err_cnt++; $display("FAIL timeout_err_log: got %h exp 0200000000", {err_count, err_addr}); end
        tick();
        // Ready on the last allowed WAIT cycle is a success.
        host_addr = 32'h0000_0010; host_req = 1'b1;
        tick();
        host_req = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 15) s_ready = 4'b0001;
            tick();
        end
        s_ready = 4'b0000;
        vec_cnt++; if ({host_ready, host_err} !== 2'b10) begin err_cnt++; $display("FAIL lastcyc_resp: got %b exp 10", {host_ready, host_err}); end
        vec_cnt++; if (host_rd !== 32'hA5A5_0000) begin err_cnt++; $display("FAIL lastcyc_rd: got %h exp a5a50000", host_rd); end
        vec_cnt++; if (err_count !== 8'd2) begin err_cnt++; $display("FAIL lastcyc_err_count: got %0d exp 2", err_count); end
        tick();
    endtask

    task automatic test_dup_and_ignore();
        host_addr = 32'h0000_0800; host_we = 1'b0; host_req2 = 1'b1;
        tick(); // cycle 1
        vec_cnt++; if (s_sel2 !== 4'b0010) begin err_cnt++; $display("FAIL dup_sel: got %b exp 0010", s_sel2); end
        // Request pulsed while busy with a different address: must be ignored.
        host_addr = 32'h0000_0904;
        tick(); // cycle 2
        host_req2 = 1'b0;
        vec_cnt++; if ({s_sel2, s_addr2} !== {4'b0010, 32'h0000_0800}) begin err_cnt++; $display("FAIL busy_ignore: got %h exp 200000800", {s_sel2, s_addr2}); end
        s_ready = 4'b0010;
        tick(); // cycle 3
        s_ready = 4'b0000;
        vec_cnt++; if ({host_ready2, host_err2} !== 2'b10) begin err_cnt++; $display("FAIL dup_resp: got %b exp 10", {host_ready2, host_err2}); end
        vec_cnt++; if (host_rd2 !== 32'hBEEF_0001) begin err_cnt++; $display("FAIL dup_rd: got %h exp beef0001", host_rd2); end
        tick(); // cycle 4
        vec_cnt++; if ({host_busy2, host_ready2, s_sel2} !== 6'd0) begin err_cnt++; $display("FAIL dup_idle: got %b exp 0", {host_busy2, host_ready2, s_sel2}); end
    endtask

    task automatic test_reset_mid();
        host_addr = 32'h0000_0904; host_req = 1'b1;
        tick();
        host_req = 1'b0;
        vec_cnt++; if (s_sel !== 4'b1000) begin err_cnt++; $display("FAIL rmid_sel: got %b exp 1000", s_sel); end
        #2 reset = 1'b0;
        #1;
        vec_cnt++; if ({host_rd, err_addr, s_addr, s_wd, err_count, s_sel, s_we, host_ready, host_err, host_busy} !== '0) begin
            err_cnt++; $display("FAIL rmid_outputs: got %h exp 0", {host_rd, err_addr, s_addr, s_wd, err_count, s_sel, s_we, host_ready, host_err, host_busy});
        end
        s_ready = 4'b1000;
        tick();
        vec_cnt++; if (host_ready !== 1'b0) begin err_cnt++; $display("FAIL rmid_no_ready: got %b exp 0", host_ready); end
        s_ready = 4'b0000;
        reset = 1'b1;
        tick();
        vec_cnt++; if ({host_ready, host_busy} !== 2'b00) begin err_cnt++; $display("FAIL rmid_after: got %b exp 00", {host_ready, host_busy}); end
    endtask

    task automatic test_saturate();
        host_addr = 32'h0000_0500;
        for (int n = 1; n <= 256; n++) begin
            host_req = 1'b1;
            tick();
            host_req = 1'b0;
            tick();
            if (n == 254 || n == 255 || n == 256) begin
                vec_cnt++; if (err_count !== ((n < 255) ? 8'(n) : 8'd255)) begin err_cnt++; $display("FAIL sat_count n=%0d: got %0d exp %0d", n, err_count, (n < 255) ? n : 255); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_write_wait();
        test_miss();
        test_timeout();
        test_dup_and_ignore();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mmio_bus_bridge.md
# mmio_bus_bridge

Parametrised memory-mapped bus bridge between the MIPS core's data port and up to NUM_SLAVES peripherals (data memory, factorial accelerator, GPIO, future blocks). It decodes a page field of the address against a per-slave page map and latches the request. It then runs a request/ready handshake with the selected slave, with a bounded wait and a timeout. It returns registered read data, or an error response for unmapped or timed-out accesses.

## Interface
Parameters:
- NUM_SLAVES, 4, number of slave ports (1..8)
- DATA_WIDTH, 32, bus data width
- ADDR_WIDTH, 32, bus address width
- PAGE_LSB, 8, lowest address bit of the page field
- PAGE_WIDTH, 4, width of the page field
- SLAVE_PAGES, {4'd9,4'd8,4'd1,4'd0}, packed NUM_SLAVES×PAGE_WIDTH page map; slice i is the page of slave i
- TIMEOUT, 15, maximum WAIT cycles before error (1..255)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- host_req  in  1  request strobe, sampled only in IDLE
- host_we  in  1  write enable of the request
- host_addr  in  ADDR_WIDTH  request address
- host_wd  in  DATA_WIDTH  write data
- host_busy  out  1  high when not in IDLE
- host_ready  out  1  one-cycle completion pulse
- host_err  out  1  error flag, valid with host_ready
- host_rd  out  DATA_WIDTH  registered read data, valid with host_ready
- s_sel  out  NUM_SLAVES  one-hot slave select
- s_we  out  NUM_SLAVES  one-hot write enable (subset of s_sel)
- s_addr  out  ADDR_WIDTH  latched address, broadcast to all slaves
- s_wd  out  DATA_WIDTH  latched write data, broadcast to all slaves
- s_ready  in  NUM_SLAVES  per-slave completion
- s_rd  in  NUM_SLAVES×DATA_WIDTH  packed per-slave read data; slice i belongs to slave i
- err_count  out  8  saturating count of error responses
- err_addr  out  ADDR_WIDTH  address of the most recent error

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if host_req=1, latch host_addr, host_we and host_wd. Decode page = host_addr[PAGE_LSB+PAGE_WIDTH-1:PAGE_LSB].
  - Hit: latch index = lowest i with SLAVE_PAGES slice i == page, then go to WAIT.
  - Miss: set error pending, go directly to RESP.
- WAIT: s_sel[idx]=1 and s_we[idx]=latched we; all other bits are 0. The timeout counter starts at 0 and increments each WAIT cycle.
  - s_ready[idx]=1: capture s_rd slice idx into host_rd, set err=0, go to RESP.
  - Counter == TIMEOUT-1 with no ready: host_rd=ERR_DATA, err=1, go to RESP.
  - s_ready bits of unselected slaves are ignored.
- RESP: host_ready=1 and host_err=err for exactly one cycle, then return to IDLE. s_sel=0.
- On an error: host_rd=ERR_DATA, err_addr is loaded with the latched address, and err_count increments, saturating at 255.
- Writes also return host_rd. It is the captured slave data on success and ERR_DATA on error.
- host_req while busy is ignored, not queued.

## Timing
- Reset (reset=0, asynchronous) sets:
  - state to IDLE
  - all outputs to 0: host_rd, err_addr, s_addr, s_wd, err_count, s_sel, s_we, host_ready, host_err, host_busy
  - the timeout counter to 0.
- Reset mid-transaction aborts it immediately. No host_ready pulse is issued, and s_sel drops in the same cycle reset asserts.
- Hit latency: request accepted at cycle 0, WAIT from cycle 1. A slave ready in cycle k (k≥1) gives host_ready in cycle k+1. The minimum is host_ready at cycle 2.
- Miss latency: host_ready with host_err=1 at cycle 1, and no slave is selected.
- Timeout: s_sel is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT). host_ready with err comes at cycle TIMEOUT+1.
- Ready on the final allowed cycle (counter == TIMEOUT-1 with s_ready=1) is a success, not a timeout.
- host_busy is high in WAIT and RESP. A new request can be accepted in the cycle after RESP.
- host_rd, host_err and err_addr hold their values until the next response.

## Test plan
- Default map, read addr 0x0000_0904, slave 3 gives s_rd=0x1234_5678 with s_ready in its first WAIT cycle -> s_sel=4'b1000 at cycle 1; host_ready, host_rd=0x1234_5678 and host_err=0 at cycle 2.
- Write addr 0x0000_0800 with wd=0x5, slave 2 ready after 3 WAIT cycles -> s_we=4'b0100 and s_wd=0x5 for cycles 1–3; host_ready at cycle 4.
- Unmapped addr 0x0000_0500 -> host_ready with host_err=1 and host_rd=0xDEAD_BEEF at cycle 1; s_sel is never asserted; err_addr=0x500; err_count=1.
- Slave 0 never ready, TIMEOUT=15 -> s_sel[0] high for cycles 1–15; host_err=1 at cycle 16; s_ready asserted on cycle 15 instead -> success.
- SLAVE_PAGES with duplicate page 8 at slaves 1 and 2 -> slave 1 is selected. host_req pulsed during WAIT -> ignored, and the first transaction completes unchanged.
- reset=0 during WAIT -> all outputs 0 in the same cycle, no host_ready; 256 consecutive misses -> err_count saturates at 255.
